// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for the 24-bit CPU datapath.
// Optional feature macro: CU_MUL_EN (opcode 0111 = R-type MUL, EXEC waits for mul_done_i).
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   opcode_i                  opcode of fetched word, captured in FETCH when instr_ready_i
//   instr_ready_i             instruction memory data valid
//   mem_ready_i, mul_done_i   data memory / multiplier completion
//   instr_read_o, ir_write_o, pc_write_o                fetch controls
//   reg_dst_o, alu_src_o, mem_to_reg_o, reg_write_o,
//   mem_read_o, mem_write_o, branch_o, alu_op_o         datapath controls
//   illegal_o, instr_done_o   one-cycle pulses
//   instr_count_o             retired-instruction count (wraps)
module multicycle_control_unit #(
   parameter int OPCODE_W = 4,
   parameter int ALUOP_W  = 2,
   parameter int ICNT_W   = 16
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic [OPCODE_W-1:0] opcode_i,
   input  logic                instr_ready_i,
   input  logic                mem_ready_i,
   input  logic                mul_done_i,
   output logic                instr_read_o,
   output logic                ir_write_o,
   output logic                pc_write_o,
   output logic                reg_dst_o,
   output logic                alu_src_o,
   output logic                mem_to_reg_o,
   output logic                reg_write_o,
   output logic                mem_read_o,
   output logic                mem_write_o,
   output logic                branch_o,
   output logic [ALUOP_W-1:0]  alu_op_o,
   output logic                illegal_o,
   output logic                instr_done_o,
   output logic [ICNT_W-1:0]   instr_count_o
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_e;
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(4'b0001);
   localparam logic [OPCODE_W-1:0] OP_LS   = OPCODE_W'(4'b0010);
   localparam logic [OPCODE_W-1:0] OP_SS   = OPCODE_W'(4'b0011);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(4'b0100);
   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(4'b0110);
   localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(4'b0111);
`ifdef CU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   state_e              state_q, state_d;
   logic [OPCODE_W-1:0] opcode_q;
   logic [ICNT_W-1:0]   count_q;
   logic                is_r, is_addi, is_ls, is_ss, is_beq, is_mul, legal;
   logic [1:0]          alu_op;
   assign is_r    = opcode_q == OP_R;
   assign is_addi = opcode_q == OP_ADDI;
   assign is_ls   = opcode_q == OP_LS;
   assign is_ss   = opcode_q == OP_SS;
   assign is_beq  = opcode_q == OP_BEQ;
   assign is_mul  = MUL_EN && opcode_q == OP_MUL;
   assign legal   = is_r | is_addi | is_ls | is_ss | is_beq | is_mul;
   assign instr_count_o = count_q;
   always_comb begin
      state_d      = state_q;
      instr_read_o = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      reg_dst_o    = 1'b0;
      alu_src_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_write_o  = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      branch_o     = 1'b0;
      alu_op       = 2'b00;
      illegal_o    = 1'b0;
      instr_done_o = 1'b0;
      case (state_q)
         FETCH: begin
            instr_read_o = 1'b1;
            ir_write_o   = instr_ready_i;
            pc_write_o   = instr_ready_i;
            state_d      = instr_ready_i ? DECODE : FETCH;
         end
         DECODE: begin
            illegal_o = !legal;
            state_d   = legal ? EXEC : FETCH;
         end
         EXEC: begin
            reg_dst_o    = is_r | is_mul;
            alu_src_o    = is_addi | is_ls | is_ss;
            alu_op       = is_mul ? 2'b11 : is_r ? 2'b01 : is_beq ? 2'b10 : 2'b00;
            branch_o     = is_beq;
            instr_done_o = is_beq;
            state_d      = is_beq ? FETCH : (is_ls | is_ss) ? MEM : (is_mul && !mul_done_i) ? EXEC : WB;
         end
         MEM: begin
            alu_src_o    = 1'b1;
            mem_read_o   = is_ls;
            mem_write_o  = is_ss;
            instr_done_o = is_ss & mem_ready_i;
            state_d      = !mem_ready_i ? MEM : is_ls ? WB : FETCH;
         end
         WB: begin
            reg_write_o  = 1'b1;
            instr_done_o = 1'b1;
            mem_to_reg_o = is_ls;
            reg_dst_o    = is_r | is_mul;
            alu_src_o    = is_addi | is_ls;
            alu_op       = is_mul ? 2'b11 : is_r ? 2'b01 : 2'b00;
            state_d      = FETCH;
         end
         default: state_d = FETCH;
      endcase
      // Outputs are forced low for the whole time reset is asserted, not just after the edge.
      if (!rst_n_i) begin
         instr_read_o = 1'b0;
         ir_write_o   = 1'b0;
         pc_write_o   = 1'b0;
         reg_dst_o    = 1'b0;
         alu_src_o    = 1'b0;
         mem_to_reg_o = 1'b0;
         reg_write_o  = 1'b0;
         mem_read_o   = 1'b0;
         mem_write_o  = 1'b0;
         branch_o     = 1'b0;
         alu_op       = 2'b00;
         illegal_o    = 1'b0;
         instr_done_o = 1'b0;
      end
      alu_op_o = ALUOP_W'(alu_op);
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= FETCH;
         opcode_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == FETCH && instr_ready_i) opcode_q <= opcode_i;
         if (instr_done_o) count_q <= count_q + ICNT_W'(1);
      end
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed checks of the multicycle control unit (ICNT_W=2 to exercise wrap).
module tb_multicycle_control_unit;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] opcode;
   logic       instr_ready, mem_ready, mul_done;
   logic       instr_read, ir_write, pc_write, reg_dst, alu_src, mem_to_reg, reg_write;
   logic       mem_read, mem_write, branch, illegal, instr_done;
   logic [1:0] alu_op;
   logic [1:0] count;
   logic [13:0] ctrl;
   int tests = 0;
   int fails = 0;
   // {instr_read, ir_write, pc_write, reg_dst, alu_src, mem_to_reg, reg_write,
   //  mem_read, mem_write, branch, alu_op[1:0], illegal, instr_done}
   localparam logic [13:0] NONE        = 14'b0_0_0_0_0_0_0_0_0_0_00_0_0;
   localparam logic [13:0] FETCH_WAIT  = 14'b1_0_0_0_0_0_0_0_0_0_00_0_0;
   localparam logic [13:0] FETCH_RDY   = 14'b1_1_1_0_0_0_0_0_0_0_00_0_0;
   localparam logic [13:0] DEC_ILL     = 14'b0_0_0_0_0_0_0_0_0_0_00_1_0;
   localparam logic [13:0] EXEC_IMM    = 14'b0_0_0_0_1_0_0_0_0_0_00_0_0;
   localparam logic [13:0] EXEC_R      = 14'b0_0_0_1_0_0_0_0_0_0_01_0_0;
   localparam logic [13:0] EXEC_BEQ    = 14'b0_0_0_0_0_0_0_0_0_1_10_0_1;
   localparam logic [13:0] MEM_LS      = 14'b0_0_0_0_1_0_0_1_0_0_00_0_0;
   localparam logic [13:0] MEM_SS      = 14'b0_0_0_0_1_0_0_0_1_0_00_0_0;
   localparam logic [13:0] MEM_SS_DONE = 14'b0_0_0_0_1_0_0_0_1_0_00_0_1;
   localparam logic [13:0] WB_ADDI     = 14'b0_0_0_0_1_0_1_0_0_0_00_0_1;
   localparam logic [13:0] WB_LS       = 14'b0_0_0_0_1_1_1_0_0_0_00_0_1;
   localparam logic [13:0] WB_R        = 14'b0_0_0_1_0_0_1_0_0_0_01_0_1;
   localparam logic [13:0] EXEC_MUL    = 14'b0_0_0_1_0_0_0_0_0_0_11_0_0;
   localparam logic [13:0] WB_MUL      = 14'b0_0_0_1_0_0_1_0_0_0_11_0_1;

   multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(2), .ICNT_W(2)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .opcode_i(opcode), .instr_ready_i(instr_ready),
      .mem_ready_i(mem_ready), .mul_done_i(mul_done), .instr_read_o(instr_read),
      .ir_write_o(ir_write), .pc_write_o(pc_write), .reg_dst_o(reg_dst), .alu_src_o(alu_src),
      .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write), .mem_read_o(mem_read),
      .mem_write_o(mem_write), .branch_o(branch), .alu_op_o(alu_op), .illegal_o(illegal),
      .instr_done_o(instr_done), .instr_count_o(count)
   );

   assign ctrl = {instr_read, ir_write, pc_write, reg_dst, alu_src, mem_to_reg, reg_write,
                  mem_read, mem_write, branch, alu_op, illegal, instr_done};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   // One clock cycle: compare control outputs mid-cycle, then advance past the rising edge.
   task automatic cyc(input string tag, input logic [13:0] exp);
      @(negedge clk);
      chk(tag, ctrl, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic cnt(input string tag, input logic [1:0] exp);
      chk(tag, {12'b0, count}, {12'b0, exp});
   endtask

   task automatic addi(input string tag, input logic [1:0] exp_cnt);
      opcode = 4'b0001; instr_ready = 1'b1;
      cyc({tag, "_f"}, FETCH_RDY);
      instr_ready = 1'b0;
      cyc({tag, "_d"}, NONE);
      cyc({tag, "_e"}, EXEC_IMM);
      cyc({tag, "_w"}, WB_ADDI);
      cnt({tag, "_cnt"}, exp_cnt);
   endtask

   initial begin
      rst_n = 1'b0; opcode = 4'b0000; instr_ready = 1'b0; mem_ready = 1'b0; mul_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_ctrl", ctrl, NONE);
         cnt("rst_cnt", 2'd0);
      end
      opcode = 4'b0001; instr_ready = 1'b1;
      @(negedge clk);
      chk("rst_gate_irwrite", ctrl, NONE);
      @(posedge clk);
      #1 rst_n = 1'b1;
      // ADDI straight out of reset, instr_ready held high (ignored outside FETCH)
      cyc("t1_fetch", FETCH_RDY);
      cyc("t1_decode", NONE);
      cyc("t1_exec", EXEC_IMM);
      cyc("t1_wb", WB_ADDI);
      cnt("t1_cnt", 2'd1);
      // LS with memory ready delayed 3 cycles; early mem_ready in EXEC must be ignored
      opcode = 4'b0010;
      cyc("t2_fetch", FETCH_RDY);
      instr_ready = 1'b0; opcode = 4'b0000;
      cyc("t2_decode", NONE);
      mem_ready = 1'b1;
      cyc("t2_exec", EXEC_IMM);
      mem_ready = 1'b0;
      cyc("t2_mem0", MEM_LS);
      cyc("t2_mem1", MEM_LS);
      cyc("t2_mem2", MEM_LS);
      mem_ready = 1'b1;
      cyc("t2_mem3", MEM_LS);
      mem_ready = 1'b0;
      cyc("t2_wb", WB_LS);
      cnt("t2_cnt", 2'd2);
      // SS with one wait cycle, then BEQ
      opcode = 4'b0011; instr_ready = 1'b1;
      cyc("t3_ss_fetch", FETCH_RDY);
      instr_ready = 1'b0;
      cyc("t3_ss_decode", NONE);
      cyc("t3_ss_exec", EXEC_IMM);
      cyc("t3_ss_mem0", MEM_SS);
      mem_ready = 1'b1;
      cyc("t3_ss_mem1", MEM_SS_DONE);
      mem_ready = 1'b0;
      cnt("t3_ss_cnt", 2'd3);
      opcode = 4'b0100; instr_ready = 1'b1;
      cyc("t3_beq_fetch", FETCH_RDY);
      instr_ready = 1'b0;
      cyc("t3_beq_decode", NONE);
      cyc("t3_beq_exec", EXEC_BEQ);
      cnt("t3_beq_cnt_wrap", 2'd0);
      cyc("t3_beq_back_fetch", FETCH_WAIT);
      // Illegal opcode
      opcode = 4'b1111; instr_ready = 1'b1;
      cyc("t4_fetch", FETCH_RDY);
      instr_ready = 1'b0;
      cyc("t4_decode_ill", DEC_ILL);
      cyc("t4_back_fetch", FETCH_WAIT);
      cnt("t4_cnt", 2'd0);
      // R-type
      opcode = 4'b0110; instr_ready = 1'b1;
      cyc("r_fetch", FETCH_RDY);
      instr_ready = 1'b0;
      cyc("r_decode", NONE);
      cyc("r_exec", EXEC_R);
      cyc("r_wb", WB_R);
      cnt("r_cnt", 2'd1);
      // Opcode 0111: MUL when enabled, illegal otherwise
      opcode = 4'b0111; instr_ready = 1'b1;
      cyc("mul_fetch", FETCH_RDY);
      instr_ready = 1'b0;
`ifdef CU_MUL_EN
      cyc("mul_decode", NONE);
      mul_done = 1'b0;
      for (int i = 0; i < 5; i++) cyc("mul_exec_wait", EXEC_MUL);
      mul_done = 1'b1;
      cyc("mul_exec_done", EXEC_MUL);
      mul_done = 1'b0;
      cyc("mul_wb", WB_MUL);
      cnt("mul_cnt", 2'd2);
`else
      mul_done = 1'b1;
      cyc("mul_decode_ill", DEC_ILL);
      mul_done = 1'b0;
      cyc("mul_back_fetch", FETCH_WAIT);
      cnt("mul_cnt", 2'd1);
`endif
      // Reset asserted mid-MEM during SS
      opcode = 4'b0011; instr_ready = 1'b1;
      cyc("t5_fetch", FETCH_RDY);
      instr_ready = 1'b0;
      cyc("t5_decode", NONE);
      cyc("t5_exec", EXEC_IMM);
      @(negedge clk);
      chk("t5_mem_before", ctrl, MEM_SS);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_drop", ctrl, NONE);
      cnt("t5_cnt_clear", 2'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc("t5_fetch_after", FETCH_WAIT);
      cnt("t5_cnt_after", 2'd0);
      // Five ADDI: counter 1,2,3,0,1
      addi("t6_a1", 2'd1);
      addi("t6_a2", 2'd2);
      addi("t6_a3", 2'd3);
      addi("t6_a4", 2'd0);
      addi("t6_a5", 2'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
